// File: rtl/branch_pkg.sv
// Shared encodings and instruction field positions for the conditional-branch sequencer.
package branch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T3   = 3'd1,
    ST_T4   = 3'd2,
    ST_T5   = 3'd3,
    ST_T6   = 3'd4
  } state_e;

  localparam logic [4:0] OPC_BR_DEF = 5'b10010;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 27;
  localparam int RA_MSB   = 26;
  localparam int RA_LSB   = 23;
  localparam int COND_MSB = 20;
  localparam int COND_LSB = 19;
  localparam int C_MSB    = 18;
  localparam int C_LSB    = 0;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterized up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_sequencer.sv
// Steps the datapath through branch phases T3-T6 after a hand-over from the fetch sequencer,
// loading PC only when the condition sampled in T3 was true.
module branch_sequencer
  import branch_pkg::*;
#(
  parameter logic [4:0] OPC_BR = OPC_BR_DEF,
  parameter int         CNT_W  = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             con_in,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             gra,
  output logic             r_out,
  output logic             con_in_en,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             z_in,
  output logic             zlow_out,
  output logic             pc_in,
  output logic [31:0]      c_sext,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        con_q, con_d;
  logic        illegal_q, illegal_d;
  logic        taken_en, not_taken_en;

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    con_d        = con_q;
    illegal_d    = 1'b0;
    gra          = 1'b0;
    r_out        = 1'b0;
    con_in_en    = 1'b0;
    pc_out       = 1'b0;
    y_in         = 1'b0;
    c_out        = 1'b0;
    alu_add      = 1'b0;
    z_in         = 1'b0;
    zlow_out     = 1'b0;
    pc_in        = 1'b0;
    done         = 1'b0;
    taken_en     = 1'b0;
    not_taken_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (ir[OPC_MSB:OPC_LSB] == OPC_BR) begin
            ir_d    = ir;
            con_d   = 1'b0;
            state_d = ST_T3;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_T3: begin
        gra       = 1'b1;
        r_out     = 1'b1;
        con_in_en = 1'b1;
        con_d     = con_in;
        state_d   = ST_T4;
      end
      ST_T4: begin
        pc_out  = 1'b1;
        y_in    = 1'b1;
        state_d = ST_T5;
      end
      ST_T5: begin
        c_out   = 1'b1;
        alu_add = 1'b1;
        z_in    = 1'b1;
        state_d = ST_T6;
      end
      ST_T6: begin
        zlow_out     = 1'b1;
        done         = 1'b1;
        pc_in        = con_q;
        taken_en     = con_q;
        not_taken_en = ~con_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // illegal is registered so that it reads zero while clear is held low
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      con_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      con_q     <= con_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign illegal = illegal_q;
  assign c_sext  = {{13{ir_q[C_MSB]}}, ir_q[C_MSB:C_LSB]};

  // Fields consumed elsewhere in the control unit; folded here to mark them intentionally unread.
  logic unused_ir;
  assign unused_ir = ^{ir_q[OPC_MSB:OPC_LSB], ir_q[RA_MSB:RA_LSB], ir_q[22:21],
                       ir_q[COND_MSB:COND_LSB]};

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clock (clock),
    .clear (clear),
    .en    (taken_en),
    .cnt   (taken_cnt)
  );

  sat_counter #(.W(CNT_W)) u_not_taken_cnt (
    .clock (clock),
    .clear (clear),
    .en    (not_taken_en),
    .cnt   (not_taken_cnt)
  );

endmodule
